// File: rtl/rf_arb_pkg.sv
// Shared types and constants for the register-file write arbiter.
// Entries carry a 3-bit push-order stamp so same-register writes retire in order.
package rf_arb_pkg;

    localparam int DATA_W  = 64;
    localparam int ADDR_W  = 6;
    localparam int NREG    = 32;
    localparam int XZR_IDX = 31;
    localparam int SEQ_W   = 3;

    typedef struct packed {
        logic [ADDR_W-1:0] wr_reg;
        logic [DATA_W-1:0] data;
        logic [SEQ_W-1:0]  seq;
    } rf_wr_entry_t;

    typedef enum logic {
        CH_A = 1'b0,
        CH_B = 1'b1
    } chan_t;

    // a is older than b when b was stamped 1..3 pushes later (modulo 8)
    function automatic logic seq_older(input logic [SEQ_W-1:0] a, input logic [SEQ_W-1:0] b);
        logic [SEQ_W-1:0] diff;
        diff = b - a;
        return (diff != 3'd0) && (diff <= 3'd3);
    endfunction

endpackage

// File: rtl/rf_wr_fifo.sv
// Two-entry write buffer; slot 0 is always the head, slot 1 shifts down on pop.
// Exposes the second entry's register index so the top can build the pending vector.
module rf_wr_fifo
    import rf_arb_pkg::*;
(
    input  logic              clock,
    input  logic              reset,
    input  logic              push,
    input  rf_wr_entry_t      push_entry,
    input  logic              pop,
    output logic              full,
    output logic              empty,
    output rf_wr_entry_t      head,
    output logic              head_valid,
    output logic [ADDR_W-1:0] second_reg,
    output logic              second_valid
);

    logic [1:0]   count_q, count_d;
    rf_wr_entry_t e0_q, e0_d;
    rf_wr_entry_t e1_q, e1_d;

    always_comb begin
        count_d = count_q;
        e0_d    = e0_q;
        e1_d    = e1_q;
        unique case ({push, pop})
            2'b10: begin
                if (count_q == 2'd0) e0_d = push_entry;
                else                 e1_d = push_entry;
                count_d = count_q + 2'd1;
            end
            2'b01: begin
                e0_d    = e1_q;
                count_d = count_q - 2'd1;
            end
            2'b11: begin
                // count stays; the incoming entry lands behind whatever remains
                if (count_q == 2'd1) begin
                    e0_d = push_entry;
                end else begin
                    e0_d = e1_q;
                    e1_d = push_entry;
                end
            end
            default: ;
        endcase
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            count_q <= '0;
            e0_q    <= '0;
            e1_q    <= '0;
        end else begin
            count_q <= count_d;
            e0_q    <= e0_d;
            e1_q    <= e1_d;
        end
    end

    assign full         = (count_q == 2'd2);
    assign empty        = (count_q == 2'd0);
    assign head         = e0_q;
    assign head_valid   = (count_q != 2'd0);
    assign second_reg   = e1_q.wr_reg;
    assign second_valid = (count_q == 2'd2);

endmodule

// File: rtl/rf_write_arbiter.sv
// Shares the register-file write port between ALU (A) and load (B) writeback,
// one write per cycle, ordering same-register writes by age and others round-robin.
module rf_write_arbiter
    import rf_arb_pkg::*;
#(
    parameter int NREG_P       = NREG,
    parameter int XZR_IDX_P    = XZR_IDX,
    parameter bit SUPPRESS_XZR = 1'b1
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              a_valid,
    output logic              a_ready,
    input  logic [ADDR_W-1:0] a_reg,
    input  logic [DATA_W-1:0] a_data,
    input  logic              b_valid,
    output logic              b_ready,
    input  logic [ADDR_W-1:0] b_reg,
    input  logic [DATA_W-1:0] b_data,
    output logic              rf_wr_en,
    output logic [ADDR_W-1:0] rf_wr_reg,
    output logic [DATA_W-1:0] rf_wr_data,
    output logic [NREG_P-1:0] pending,
    output logic              idle
);

    logic              a_full, a_empty, a_hv, a_sv;
    logic              b_full, b_empty, b_hv, b_sv;
    rf_wr_entry_t      a_head, b_head, a_new, b_new;
    logic [ADDR_W-1:0] a_second_reg, b_second_reg;
    logic              a_fire, b_fire, a_push, b_push;
    logic              grant_a, grant_b;

    logic [SEQ_W-1:0]  seq_q, seq_d;
    chan_t             rr_q, rr_d;
    logic              wr_en_q, wr_en_d;
    logic [ADDR_W-1:0] wr_reg_q, wr_reg_d;
    logic [DATA_W-1:0] wr_data_q, wr_data_d;

    assign a_ready = ~a_full;
    assign b_ready = ~b_full;
    assign a_fire  = a_valid & a_ready;
    assign b_fire  = b_valid & b_ready;
    assign a_push  = a_fire & ~(SUPPRESS_XZR && (a_reg == ADDR_W'(XZR_IDX_P)));
    assign b_push  = b_fire & ~(SUPPRESS_XZR && (b_reg == ADDR_W'(XZR_IDX_P)));
    assign a_new   = '{wr_reg: a_reg, data: a_data, seq: seq_q};
    assign b_new   = '{wr_reg: b_reg, data: b_data, seq: seq_q};

    rf_wr_fifo u_fifo_a (
        .clock        (clock),
        .reset        (reset),
        .push         (a_push),
        .push_entry   (a_new),
        .pop          (grant_a),
        .full         (a_full),
        .empty        (a_empty),
        .head         (a_head),
        .head_valid   (a_hv),
        .second_reg   (a_second_reg),
        .second_valid (a_sv)
    );

    rf_wr_fifo u_fifo_b (
        .clock        (clock),
        .reset        (reset),
        .push         (b_push),
        .push_entry   (b_new),
        .pop          (grant_b),
        .full         (b_full),
        .empty        (b_empty),
        .head         (b_head),
        .head_valid   (b_hv),
        .second_reg   (b_second_reg),
        .second_valid (b_sv)
    );

    // Any non-age grant hands priority to the other channel; age grants leave it alone.
    always_comb begin
        grant_a = 1'b0;
        grant_b = 1'b0;
        rr_d    = rr_q;
        if (a_hv && b_hv) begin
            if (a_head.wr_reg == b_head.wr_reg) begin
                if (seq_older(b_head.seq, a_head.seq)) grant_b = 1'b1;
                else                                   grant_a = 1'b1;
            end else if (rr_q == CH_A) begin
                grant_a = 1'b1;
                rr_d    = CH_B;
            end else begin
                grant_b = 1'b1;
                rr_d    = CH_A;
            end
        end else if (a_hv) begin
            grant_a = 1'b1;
            rr_d    = CH_B;
        end else if (b_hv) begin
            grant_b = 1'b1;
            rr_d    = CH_A;
        end
    end

    always_comb begin
        seq_d     = (a_fire || b_fire) ? seq_q + 3'd1 : seq_q;
        wr_en_d   = grant_a | grant_b;
        wr_reg_d  = wr_reg_q;
        wr_data_d = wr_data_q;
        if (grant_a) begin
            wr_reg_d  = a_head.wr_reg;
            wr_data_d = a_head.data;
        end else if (grant_b) begin
            wr_reg_d  = b_head.wr_reg;
            wr_data_d = b_head.data;
        end
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            seq_q     <= '0;
            rr_q      <= CH_A;
            wr_en_q   <= 1'b0;
            wr_reg_q  <= '0;
            wr_data_q <= '0;
        end else begin
            seq_q     <= seq_d;
            rr_q      <= rr_d;
            wr_en_q   <= wr_en_d;
            wr_reg_q  <= wr_reg_d;
            wr_data_q <= wr_data_d;
        end
    end

    always_comb begin
        pending = '0;
        for (int unsigned r = 0; r < NREG_P; r++) begin
            pending[r] = (a_hv    && a_head.wr_reg == ADDR_W'(r)) ||
                         (a_sv    && a_second_reg  == ADDR_W'(r)) ||
                         (b_hv    && b_head.wr_reg == ADDR_W'(r)) ||
                         (b_sv    && b_second_reg  == ADDR_W'(r)) ||
                         (wr_en_q && wr_reg_q      == ADDR_W'(r));
        end
    end

    assign rf_wr_en   = wr_en_q;
    assign rf_wr_reg  = wr_reg_q;
    assign rf_wr_data = wr_data_q;
    assign idle       = a_empty & b_empty & ~wr_en_q;

endmodule

// File: tb/tb_rf_write_arbiter.sv
// Bench for rf_write_arbiter: directed scenarios plus a queue-level scoreboard
// that re-derives every issued write, pending, ready and idle each cycle.
module tb_rf_write_arbiter;

    logic        clock = 1'b0;
    logic        reset = 1'b1;
    logic        a_valid = 1'b0, b_valid = 1'b0;
    logic        a_ready, b_ready;
    logic [5:0]  a_reg = '0, b_reg = '0;
    logic [63:0] a_data = '0, b_data = '0;
    logic        rf_wr_en;
    logic [5:0]  rf_wr_reg;
    logic [63:0] rf_wr_data;
    logic [31:0] pending;
    logic        idle;

    logic        nx_a_valid = 1'b0;
    logic        nx_a_ready, nx_b_ready;
    logic [5:0]  nx_a_reg = '0;
    logic [63:0] nx_a_data = '0;
    logic        nx_rf_wr_en;
    logic [5:0]  nx_rf_wr_reg;
    logic [63:0] nx_rf_wr_data;
    logic [31:0] nx_pending;
    logic        nx_idle;

    int n_checks = 0;
    int n_errors = 0;

    rf_write_arbiter u_dut (
        .clock      (clock),
        .reset      (reset),
        .a_valid    (a_valid),
        .a_ready    (a_ready),
        .a_reg      (a_reg),
        .a_data     (a_data),
        .b_valid    (b_valid),
        .b_ready    (b_ready),
        .b_reg      (b_reg),
        .b_data     (b_data),
        .rf_wr_en   (rf_wr_en),
        .rf_wr_reg  (rf_wr_reg),
        .rf_wr_data (rf_wr_data),
        .pending    (pending),
        .idle       (idle)
    );

    rf_write_arbiter #(.SUPPRESS_XZR(1'b0)) u_dut_nx (
        .clock      (clock),
        .reset      (reset),
        .a_valid    (nx_a_valid),
        .a_ready    (nx_a_ready),
        .a_reg      (nx_a_reg),
        .a_data     (nx_a_data),
        .b_valid    (1'b0),
        .b_ready    (nx_b_ready),
        .b_reg      (6'd0),
        .b_data     (64'd0),
        .rf_wr_en   (nx_rf_wr_en),
        .rf_wr_reg  (nx_rf_wr_reg),
        .rf_wr_data (nx_rf_wr_data),
        .pending    (nx_pending),
        .idle       (nx_idle)
    );

    always #5 clock = ~clock;

    // Scoreboard: per-channel queues of accepted, not-yet-issued writes,
    // each tagged with the edge index at which it was accepted (its age).
    typedef struct {
        int unsigned rg;
        logic [63:0] data;
        int          acc;
    } wr_t;

    wr_t         qa[$];
    wr_t         qb[$];
    int          cyc = 0;
    bit          pref_b = 1'b0;
    logic [5:0]  last_reg = '0;
    logic [63:0] last_data = '0;

    always @(negedge clock) begin
        bit          ca, cb;
        int          pick;
        wr_t         e;
        logic [31:0] pexp;
        cyc++;
        if (reset) begin
            qa.delete();
            qb.delete();
            pref_b    = 1'b0;
            last_reg  = '0;
            last_data = '0;
        end else begin
            // heads that were already buffered before the edge that just issued
            ca = (qa.size() > 0) && (qa[0].acc < cyc - 1);
            cb = (qb.size() > 0) && (qb[0].acc < cyc - 1);
            pick = 0;
            if (ca && cb) begin
                if (qa[0].rg == qb[0].rg) pick = (qb[0].acc < qa[0].acc) ? 2 : 1;
                else begin
                    pick   = pref_b ? 2 : 1;
                    pref_b = (pick == 1);
                end
            end else if (ca) begin
                pick   = 1;
                pref_b = 1'b1;
            end else if (cb) begin
                pick   = 2;
                pref_b = 1'b0;
            end

            n_checks++;
            if (rf_wr_en !== (pick != 0)) begin
                n_errors++;
                $display("FAIL sb_wr_en cyc=%0d: got %b expected %b", cyc, rf_wr_en, pick != 0);
            end
            if (pick != 0) begin
                e = (pick == 1) ? qa.pop_front() : qb.pop_front();
                n_checks++;
                if (rf_wr_reg !== 6'(e.rg) || rf_wr_data !== e.data) begin
                    n_errors++;
                    $display("FAIL sb_write cyc=%0d: got reg %0d data %h expected reg %0d data %h",
                             cyc, rf_wr_reg, rf_wr_data, e.rg, e.data);
                end
                last_reg  = 6'(e.rg);
                last_data = e.data;
            end else begin
                n_checks++;
                if (rf_wr_reg !== last_reg || rf_wr_data !== last_data) begin
                    n_errors++;
                    $display("FAIL sb_hold cyc=%0d: got reg %0d data %h expected reg %0d data %h",
                             cyc, rf_wr_reg, rf_wr_data, last_reg, last_data);
                end
            end

            pexp = '0;
            foreach (qa[i]) if (qa[i].rg < 32) pexp[qa[i].rg] = 1'b1;
            foreach (qb[i]) if (qb[i].rg < 32) pexp[qb[i].rg] = 1'b1;
            if (rf_wr_en === 1'b1 && rf_wr_reg < 6'd32) pexp[rf_wr_reg[4:0]] = 1'b1;
            n_checks++;
            if (pending !== pexp) begin
                n_errors++;
                $display("FAIL sb_pending cyc=%0d: got %h expected %h", cyc, pending, pexp);
            end
            n_checks++;
            if (a_ready !== (qa.size() < 2) || b_ready !== (qb.size() < 2)) begin
                n_errors++;
                $display("FAIL sb_ready cyc=%0d: got a=%b b=%b expected a=%b b=%b",
                         cyc, a_ready, b_ready, qa.size() < 2, qb.size() < 2);
            end
            n_checks++;
            if (idle !== (qa.size() == 0 && qb.size() == 0 && rf_wr_en === 1'b0)) begin
                n_errors++;
                $display("FAIL sb_idle cyc=%0d: got %b", cyc, idle);
            end

            if (a_valid && a_ready && a_reg != 6'd31) qa.push_back('{rg: a_reg, data: a_data, acc: cyc});
            if (b_valid && b_ready && b_reg != 6'd31) qb.push_back('{rg: b_reg, data: b_data, acc: cyc});
        end
    end

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic drain();
        int n;
        n = 0;
        while (!idle && n < 40) begin
            tick();
            n++;
        end
        n_checks++;
        if (idle !== 1'b1) begin
            n_errors++;
            $display("FAIL drain_timeout: idle got %b expected 1", idle);
        end
    endtask

    task automatic test_reset();
        #12;
        n_checks++;
        if (rf_wr_en !== 1'b0 || rf_wr_reg !== 6'd0 || rf_wr_data !== 64'd0 ||
            pending !== 32'd0 || idle !== 1'b1 || a_ready !== 1'b1 || b_ready !== 1'b1) begin
            n_errors++;
            $display("FAIL reset_state: got en=%b reg=%0d data=%h pend=%h idle=%b ar=%b br=%b expected 0 0 0 0 1 1 1",
                     rf_wr_en, rf_wr_reg, rf_wr_data, pending, idle, a_ready, b_ready);
        end
        #1 reset = 1'b0;
    endtask

    task automatic test_diff_regs();
        for (int rep = 0; rep < 2; rep++) begin
            tick();
            a_valid = 1'b1; a_reg = 6'd3; a_data = 64'h33;
            b_valid = 1'b1; b_reg = 6'd4; b_data = 64'h44;
            tick();
            a_valid = 1'b0; b_valid = 1'b0;
            tick();
            n_checks++;
            if (rf_wr_en !== 1'b1 || rf_wr_reg !== 6'd3 || rf_wr_data !== 64'h33) begin
                n_errors++;
                $display("FAIL diff_first rep%0d: got en=%b reg=%0d expected en=1 reg=3", rep, rf_wr_en, rf_wr_reg);
            end
            tick();
            n_checks++;
            if (rf_wr_en !== 1'b1 || rf_wr_reg !== 6'd4 || rf_wr_data !== 64'h44) begin
                n_errors++;
                $display("FAIL diff_second rep%0d: got en=%b reg=%0d expected en=1 reg=4", rep, rf_wr_en, rf_wr_reg);
            end
            tick();
        end
    endtask

    task automatic test_single_a();
        tick();
        a_valid = 1'b1; a_reg = 6'd5; a_data = 64'hDEAD;
        tick();
        a_valid = 1'b0;
        n_checks++;
        if (pending[5] !== 1'b1 || rf_wr_en !== 1'b0 || idle !== 1'b0) begin
            n_errors++;
            $display("FAIL single_buffered: got pend5=%b en=%b idle=%b expected 1 0 0", pending[5], rf_wr_en, idle);
        end
        tick();
        n_checks++;
        if (rf_wr_en !== 1'b1 || rf_wr_reg !== 6'd5 || rf_wr_data !== 64'hDEAD || pending[5] !== 1'b1) begin
            n_errors++;
            $display("FAIL single_issue: got en=%b reg=%0d data=%h pend5=%b expected 1 5 dead 1",
                     rf_wr_en, rf_wr_reg, rf_wr_data, pending[5]);
        end
        tick();
        n_checks++;
        if (rf_wr_en !== 1'b0 || pending[5] !== 1'b0 || idle !== 1'b1) begin
            n_errors++;
            $display("FAIL single_done: got en=%b pend5=%b idle=%b expected 0 0 1", rf_wr_en, pending[5], idle);
        end
    endtask

    task automatic test_same_reg();
        tick();
        b_valid = 1'b1; b_reg = 6'd7; b_data = 64'd1;
        tick();
        b_valid = 1'b0;
        a_valid = 1'b1; a_reg = 6'd7; a_data = 64'd2;
        tick();
        a_valid = 1'b0;
        n_checks++;
        if (rf_wr_en !== 1'b1 || rf_wr_reg !== 6'd7 || rf_wr_data !== 64'd1) begin
            n_errors++;
            $display("FAIL same_older_first: got en=%b data=%h expected en=1 data=1", rf_wr_en, rf_wr_data);
        end
        tick();
        n_checks++;
        if (rf_wr_en !== 1'b1 || rf_wr_data !== 64'd2) begin
            n_errors++;
            $display("FAIL same_younger_second: got en=%b data=%h expected en=1 data=2", rf_wr_en, rf_wr_data);
        end
        // priority now rests on B, so equal-age ordering must still pick A
        tick();
        a_valid = 1'b1; a_reg = 6'd7; a_data = 64'hA;
        b_valid = 1'b1; b_reg = 6'd7; b_data = 64'hB;
        tick();
        a_valid = 1'b0; b_valid = 1'b0;
        tick();
        n_checks++;
        if (rf_wr_en !== 1'b1 || rf_wr_data !== 64'hA) begin
            n_errors++;
            $display("FAIL same_tie_a_first: got en=%b data=%h expected en=1 data=a", rf_wr_en, rf_wr_data);
        end
        tick();
        n_checks++;
        if (rf_wr_en !== 1'b1 || rf_wr_data !== 64'hB) begin
            n_errors++;
            $display("FAIL same_tie_b_second: got en=%b data=%h expected en=1 data=b", rf_wr_en, rf_wr_data);
        end
        drain();
    endtask

    task automatic test_xzr();
        bit saw_en;
        tick();
        a_valid = 1'b1; a_reg = 6'd31; a_data = 64'h1;
        nx_a_valid = 1'b1; nx_a_reg = 6'd31; nx_a_data = 64'h1;
        tick();
        a_valid = 1'b0; nx_a_valid = 1'b0;
        n_checks++;
        if (a_ready !== 1'b1 || pending[31] !== 1'b0 || idle !== 1'b1) begin
            n_errors++;
            $display("FAIL xzr_drop: got ready=%b pend31=%b idle=%b expected 1 0 1", a_ready, pending[31], idle);
        end
        n_checks++;
        if (nx_pending[31] !== 1'b1) begin
            n_errors++;
            $display("FAIL xzr_keep_pending: got %b expected 1", nx_pending[31]);
        end
        saw_en = 1'b0;
        for (int i = 0; i < 3; i++) begin
            tick();
            if (rf_wr_en === 1'b1) saw_en = 1'b1;
            if (i == 0) begin
                n_checks++;
                if (nx_rf_wr_en !== 1'b1 || nx_rf_wr_reg !== 6'd31 || nx_rf_wr_data !== 64'h1) begin
                    n_errors++;
                    $display("FAIL xzr_keep_issue: got en=%b reg=%0d expected en=1 reg=31", nx_rf_wr_en, nx_rf_wr_reg);
                end
            end
        end
        n_checks++;
        if (saw_en !== 1'b0) begin
            n_errors++;
            $display("FAIL xzr_no_write: got write seen=%b expected 0", saw_en);
        end
    endtask

    task automatic test_backpressure();
        int  a_sent, b_sent;
        bit  saw_full;
        a_sent = 0; b_sent = 0; saw_full = 1'b0;
        for (int i = 0; i < 24; i++) begin
            a_valid = (a_sent < 5);
            a_reg   = 6'(20 + a_sent);
            a_data  = 64'(32'hA000 + a_sent);
            b_valid = (b_sent < 12);
            b_reg   = 6'(10 + (b_sent % 4));
            b_data  = 64'(32'hB000 + b_sent);
            if (a_valid && !a_ready) saw_full = 1'b1;
            if (a_valid && a_ready) a_sent++;
            if (b_valid && b_ready) b_sent++;
            tick();
        end
        a_valid = 1'b0; b_valid = 1'b0;
        n_checks++;
        if (saw_full !== 1'b1 || a_sent != 5 || b_sent != 12) begin
            n_errors++;
            $display("FAIL backpressure: got full_seen=%b a_sent=%0d b_sent=%0d expected 1 5 12", saw_full, a_sent, b_sent);
        end
        drain();
    endtask

    task automatic test_random();
        int unsigned pk;
        for (int i = 0; i < 400; i++) begin
            a_valid = 1'($urandom_range(0, 1));
            pk      = $urandom_range(0, 9);
            a_reg   = (pk < 8) ? 6'(pk) : ((pk == 8) ? 6'd31 : 6'd40);
            a_data  = {$urandom(), $urandom()};
            b_valid = 1'($urandom_range(0, 1));
            pk      = $urandom_range(0, 9);
            b_reg   = (pk < 8) ? 6'(pk) : ((pk == 8) ? 6'd31 : 6'd40);
            b_data  = {$urandom(), $urandom()};
            tick();
        end
        a_valid = 1'b0; b_valid = 1'b0;
        drain();
    endtask

    task automatic test_reset_mid();
        bit saw_en;
        tick();
        a_valid = 1'b1; a_reg = 6'd1; a_data = 64'h11;
        b_valid = 1'b1; b_reg = 6'd2; b_data = 64'h22;
        tick();
        a_reg = 6'd3; a_data = 64'h33;
        b_reg = 6'd4; b_data = 64'h44;
        tick();
        a_valid = 1'b0; b_valid = 1'b0;
        n_checks++;
        if (rf_wr_en !== 1'b1 || idle !== 1'b0) begin
            n_errors++;
            $display("FAIL reset_mid_busy: got en=%b idle=%b expected 1 0", rf_wr_en, idle);
        end
        #2 reset = 1'b1;
        #1;
        n_checks++;
        if (rf_wr_en !== 1'b0 || pending !== 32'd0 || idle !== 1'b1) begin
            n_errors++;
            $display("FAIL reset_mid_async: got en=%b pend=%h idle=%b expected 0 0 1", rf_wr_en, pending, idle);
        end
        tick();
        #2 reset = 1'b0;
        saw_en = 1'b0;
        for (int i = 0; i < 6; i++) begin
            tick();
            if (rf_wr_en !== 1'b0) saw_en = 1'b1;
        end
        n_checks++;
        if (saw_en !== 1'b0 || idle !== 1'b1) begin
            n_errors++;
            $display("FAIL reset_mid_flush: got write seen=%b idle=%b expected 0 1", saw_en, idle);
        end
    endtask

    initial begin
        test_reset();
        test_diff_regs();
        test_single_a();
        test_same_reg();
        test_xzr();
        test_backpressure();
        test_random();
        test_reset_mid();
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
